ctl_round: RTL and testbench
============================

Name: ctl_round

Overview:
Game-round sequencer that schedules the duck datapath: ctl_duck, ctl_ammo and the overlay.
- Decides when each duck launches, when it must fly away (shots exhausted or timeout), and when ammo is refilled.
- Counts ducks and hits per round, and decides between round advance and game over.
- Sits in the ctrl section of top_DH, between the input/trigger logic (hit, shot_fired, pause, reload) and ctl_duck/ctl_ammo.

Parameters:
DUCKS_PER_ROUND, 10, ducks launched per round (1..15)
SHOTS_PER_DUCK, 3, shots allowed per duck before forced escape (1..7)
SPAWN_DELAY_FRAMES, 60, frames between duck end and next launch
ESCAPE_FRAMES, 600, max flight frames before forced escape
RESULT_FRAMES, 90, frames the round result is held
PASS_HITS, 6, minimum hits to advance a round

Ports:
clk  in  1  system clock, 65 MHz
rst  in  1  reset
new_frame  in  1  one-cycle pulse per VGA frame
start  in  1  one-cycle pulse, debounced reload/start request
pause  in  1  level; freezes all frame timers
hit  in  1  one-cycle pulse from ctl_trigger
shot_fired  in  1  one-cycle pulse from ctl_trigger
duck_show  in  1  level from ctl_duck; high while duck on screen/falling
duck_launch  out  1  one-cycle pulse to ctl_duck game_start
duck_escape  out  1  level; commands ctl_duck fly-away
ammo_reload  out  1  one-cycle pulse to ctl_ammo reset_score
round_num  out  4  current round, starts at 1
duck_idx  out  4  ducks completed in current round
hits_in_round  out  4  hits in current round
state_code  out  3  encoded FSM state, for overlay/debug
game_over  out  1  level, high in GAME_OVER

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. rst=0 sampled on a clk edge puts the block in reset.
- Reset values:
  - state IDLE
  - round_num=1, duck_idx=0, hits_in_round=0
  - all pulse outputs 0, duck_escape=0, game_over=0
  - frame timer 0, shot counter 0
- All outputs are registered. A pulse output is high for exactly one clk, in the cycle after the transition that causes it.
- Frame timer: 10-bit, loaded on state entry, decremented only on new_frame with pause=0. Expiry = timer==0 at a qualifying new_frame.
- IDLE: start -> SPAWN_WAIT. Same transition: ammo_reload pulse, round_num=1, counters cleared.
- SPAWN_WAIT: timer=SPAWN_DELAY_FRAMES; expiry -> FLIGHT with duck_launch pulse and shot counter cleared.
- FLIGHT: timer=ESCAPE_FRAMES.
  - hit -> DUCK_DONE; hits_in_round +1, saturating at 15.
  - shot_fired without hit -> shot counter +1; on reaching SHOTS_PER_DUCK -> ESCAPE.
  - timer expiry -> ESCAPE.
  - hit and shot_fired in the same cycle: the hit wins and the shot is not counted.
- ESCAPE: duck_escape=1; hit still accepted (hits +1, -> DUCK_DONE). duck_show low -> DUCK_DONE.
- DUCK_DONE: duck_escape=0; waits for duck_show=0.
  - If duck_idx+1 == DUCKS_PER_ROUND -> ROUND_RESULT.
  - Otherwise -> SPAWN_WAIT with ammo_reload pulse.
  - duck_idx is incremented in both cases.
- ROUND_RESULT: timer=RESULT_FRAMES. On expiry:
  - hits_in_round >= PASS_HITS -> SPAWN_WAIT; round_num +1 (saturate 15); duck_idx and hits cleared; ammo_reload pulse.
  - Otherwise -> GAME_OVER.
- GAME_OVER: game_over=1; start -> same actions as IDLE start.
- start in any non-IDLE state: abort to SPAWN_WAIT with the full IDLE-start actions. duck_escape drops in the next cycle.
- pause=1: hit, shot_fired and new_frame are ignored for timing and counting. The state is held; start is still honoured.
- hit or shot_fired outside FLIGHT/ESCAPE: ignored.
- state_code mapping: IDLE=0, SPAWN_WAIT=1, FLIGHT=2, ESCAPE=3, DUCK_DONE=4, ROUND_RESULT=5, GAME_OVER=6.
- Reset mid-flight: all outputs return to reset values on the next edge with rst=0.

Decomposition:
- DH_pkg holds:
  - round_state_t, a 3-bit enum with the codes above
  - defaults DUCKS_PER_ROUND, SHOTS_PER_DUCK, PASS_HITS, SPAWN_DELAY_FRAMES, ESCAPE_FRAMES, RESULT_FRAMES
- Sub-module frame_timer: 10-bit loadable down-counter.
  - Ports: clk, rst, load, load_val, tick (new_frame & ~pause), expired.
  - Reused for the spawn, escape and result timers.

Test Plan:
- Reset then start -> ammo_reload pulse next cycle; after 61 new_frames one duck_launch pulse; state_code=2.
- In FLIGHT, 3 shot_fired without hit -> state_code=3, duck_escape=1; duck_show low -> duck_idx=1, ammo_reload pulse.
- hit and shot_fired in the same cycle in FLIGHT -> hits_in_round=1, shot counter unchanged, state DUCK_DONE.
- 10 ducks with 6 hits -> ROUND_RESULT; after 90 frames round_num=2, hits_in_round=0, duck_idx=0. With 5 hits -> game_over=1.
- pause high for 200 frames during FLIGHT -> no escape timeout, hit ignored. Release, then 600 frames -> duck_escape=1.
- start pulse during ESCAPE -> next cycle duck_escape=0, state_code=1, round_num=1, counters cleared.

Source files
------------

// File: rtl/ctl_round_pkg.sv
// Shared types and default timing/scoring constants for the duck-hunt round sequencer.
package ctl_round_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SPAWN_WAIT   = 3'd1,
        ST_FLIGHT       = 3'd2,
        ST_ESCAPE       = 3'd3,
        ST_DUCK_DONE    = 3'd4,
        ST_ROUND_RESULT = 3'd5,
        ST_GAME_OVER    = 3'd6
    } round_state_t;

    localparam int unsigned TIMER_W                = 10;
    localparam int unsigned DEF_DUCKS_PER_ROUND    = 10;
    localparam int unsigned DEF_SHOTS_PER_DUCK     = 3;
    localparam int unsigned DEF_PASS_HITS          = 6;
    localparam int unsigned DEF_SPAWN_DELAY_FRAMES = 60;
    localparam int unsigned DEF_ESCAPE_FRAMES      = 600;
    localparam int unsigned DEF_RESULT_FRAMES      = 90;

endpackage

// File: rtl/ctl_round_if.sv
// Event inputs from trigger/duck logic and sequencer outputs to ctl_duck, ctl_ammo and the overlay.
interface ctl_round_if;
    import ctl_round_pkg::*;

    logic       new_frame;
    logic       start;
    logic       pause;
    logic       hit;
    logic       shot_fired;
    logic       duck_show;
    logic       duck_launch;
    logic       duck_escape;
    logic       ammo_reload;
    logic [3:0] round_num;
    logic [3:0] duck_idx;
    logic [3:0] hits_in_round;
    logic [2:0] state_code;
    logic       game_over;

    modport master (
        output new_frame, start, pause, hit, shot_fired, duck_show,
        input  duck_launch, duck_escape, ammo_reload, round_num, duck_idx,
               hits_in_round, state_code, game_over
    );

    modport slave (
        input  new_frame, start, pause, hit, shot_fired, duck_show,
        output duck_launch, duck_escape, ammo_reload, round_num, duck_idx,
               hits_in_round, state_code, game_over
    );

endinterface

// File: rtl/ctl_round_frame_timer.sv
// Loadable frame down-counter; expires on a tick that finds the count already at zero.
module ctl_round_frame_timer
    import ctl_round_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic               expired
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = tick && (count_q == '0);

endmodule

// File: rtl/ctl_round.sv
// Round sequencer: schedules duck launch/escape, ammo refill, and round advance or game over.
module ctl_round
    import ctl_round_pkg::*;
#(
    parameter int unsigned DUCKS_PER_ROUND    = DEF_DUCKS_PER_ROUND,
    parameter int unsigned SHOTS_PER_DUCK     = DEF_SHOTS_PER_DUCK,
    parameter int unsigned SPAWN_DELAY_FRAMES = DEF_SPAWN_DELAY_FRAMES,
    parameter int unsigned ESCAPE_FRAMES      = DEF_ESCAPE_FRAMES,
    parameter int unsigned RESULT_FRAMES      = DEF_RESULT_FRAMES,
    parameter int unsigned PASS_HITS          = DEF_PASS_HITS
) (
    input  logic        clk,
    input  logic        rst,
    ctl_round_if.slave  bus
);

    localparam logic [3:0]         DUCKS_L  = 4'(DUCKS_PER_ROUND);
    localparam logic [2:0]         SHOTS_L  = 3'(SHOTS_PER_DUCK);
    localparam logic [3:0]         PASS_L   = 4'(PASS_HITS);
    localparam logic [TIMER_W-1:0] SPAWN_L  = TIMER_W'(SPAWN_DELAY_FRAMES);
    localparam logic [TIMER_W-1:0] ESCAPE_L = TIMER_W'(ESCAPE_FRAMES);
    localparam logic [TIMER_W-1:0] RESULT_L = TIMER_W'(RESULT_FRAMES);

    round_state_t       state_q, state_n;
    logic [3:0]         round_q, round_n;
    logic [3:0]         didx_q, didx_n;
    logic [3:0]         hits_q, hits_n;
    logic [2:0]         shots_q, shots_n;
    logic               launch_q, launch_n;
    logic               reload_q, reload_n;
    logic               escape_q, gover_q;
    logic               tick, expired, tmr_load;
    logic [TIMER_W-1:0] tmr_val;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [TIMER_W-1:0] entry_frames(input round_state_t s);
        case (s)
            ST_SPAWN_WAIT:   return SPAWN_L;
            ST_FLIGHT:       return ESCAPE_L;
            ST_ROUND_RESULT: return RESULT_L;
            default:         return '0;
        endcase
    endfunction

    assign tick = bus.new_frame & ~bus.pause;

    // Reloading on every state change (and on an abort into SPAWN_WAIT) gives each timed state a fresh count.
    assign tmr_load = bus.start | (state_n != state_q);
    assign tmr_val  = entry_frames(state_n);

    ctl_round_frame_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick),
        .expired  (expired)
    );

    always_comb begin
        state_n  = state_q;
        round_n  = round_q;
        didx_n   = didx_q;
        hits_n   = hits_q;
        shots_n  = shots_q;
        launch_n = 1'b0;
        reload_n = 1'b0;

        if (bus.start) begin
            // A start request restarts the game from any state, pause included.
            state_n  = ST_SPAWN_WAIT;
            round_n  = 4'd1;
            didx_n   = 4'd0;
            hits_n   = 4'd0;
            shots_n  = 3'd0;
            reload_n = 1'b1;
        end else if (!bus.pause) begin
            case (state_q)
                ST_SPAWN_WAIT: begin
                    if (expired) begin
                        state_n  = ST_FLIGHT;
                        shots_n  = 3'd0;
                        launch_n = 1'b1;
                    end
                end
                ST_FLIGHT: begin
                    if (bus.hit) begin
                        hits_n  = sat_inc4(hits_q);
                        state_n = ST_DUCK_DONE;
                    end else begin
                        if (bus.shot_fired) shots_n = shots_q + 3'd1;
                        if ((bus.shot_fired && (shots_n == SHOTS_L)) || expired)
                            state_n = ST_ESCAPE;
                    end
                end
                ST_ESCAPE: begin
                    if (bus.hit) begin
                        hits_n  = sat_inc4(hits_q);
                        state_n = ST_DUCK_DONE;
                    end else if (!bus.duck_show) begin
                        state_n = ST_DUCK_DONE;
                    end
                end
                ST_DUCK_DONE: begin
                    if (!bus.duck_show) begin
                        didx_n = didx_q + 4'd1;
                        if (didx_n == DUCKS_L) begin
                            state_n = ST_ROUND_RESULT;
                        end else begin
                            state_n  = ST_SPAWN_WAIT;
                            reload_n = 1'b1;
                        end
                    end
                end
                ST_ROUND_RESULT: begin
                    if (expired) begin
                        if (hits_q >= PASS_L) begin
                            state_n  = ST_SPAWN_WAIT;
                            round_n  = sat_inc4(round_q);
                            didx_n   = 4'd0;
                            hits_n   = 4'd0;
                            reload_n = 1'b1;
                        end else begin
                            state_n = ST_GAME_OVER;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            round_q  <= 4'd1;
            didx_q   <= 4'd0;
            hits_q   <= 4'd0;
            shots_q  <= 3'd0;
            launch_q <= 1'b0;
            reload_q <= 1'b0;
            escape_q <= 1'b0;
            gover_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            round_q  <= round_n;
            didx_q   <= didx_n;
            hits_q   <= hits_n;
            shots_q  <= shots_n;
            launch_q <= launch_n;
            reload_q <= reload_n;
            escape_q <= (state_n == ST_ESCAPE);
            gover_q  <= (state_n == ST_GAME_OVER);
        end
    end

    assign bus.duck_launch   = launch_q;
    assign bus.duck_escape   = escape_q;
    assign bus.ammo_reload   = reload_q;
    assign bus.round_num     = round_q;
    assign bus.duck_idx      = didx_q;
    assign bus.hits_in_round = hits_q;
    assign bus.state_code    = state_q;
    assign bus.game_over     = gover_q;

endmodule

// File: tb/tb_ctl_round.sv
// Scoreboard bench for ctl_round: directed stimulus queues expected status and pulses, a monitor checks them.
module tb_ctl_round;
    import ctl_round_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ctl_round_if bus ();

    ctl_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       esc;
        logic       go;
        logic [3:0] rnd;
        logic [3:0] didx;
        logic [3:0] hits;
    } snap_t;

    typedef struct {
        int cyc;
        int kind;
    } pulse_t;

    localparam int P_LAUNCH = 0;
    localparam int P_RELOAD = 1;

    snap_t  snap_q[$];
    pulse_t pulse_q[$];
    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_round, exp_didx, exp_hits;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectations are stamped with the cycle after the next clock edge.
    task automatic expect_state(input round_state_t st, input logic esc, input logic go);
        snap_t s;
        s.cyc  = cyc + 1;
        s.st   = st;
        s.esc  = esc;
        s.go   = go;
        s.rnd  = 4'(exp_round);
        s.didx = 4'(exp_didx);
        s.hits = 4'(exp_hits);
        snap_q.push_back(s);
    endtask

    task automatic expect_pulse(input int kind);
        pulse_t p;
        p.cyc  = cyc + 1;
        p.kind = kind;
        pulse_q.push_back(p);
    endtask

    task automatic clk1(input logic nf, input logic st, input logic h, input logic sf);
        bus.new_frame  = nf;
        bus.start      = st;
        bus.hit        = h;
        bus.shot_fired = sf;
        @(negedge clk);
        bus.new_frame  = 1'b0;
        bus.start      = 1'b0;
        bus.hit        = 1'b0;
        bus.shot_fired = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) clk1(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Spawn wait, launch, then either a hit or three missed shots, then the duck leaves the screen.
    task automatic run_duck(input bit do_hit);
        frames(60);
        expect_pulse(P_LAUNCH);
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        frames(1);
        bus.duck_show = 1'b1;
        if (do_hit) begin
            exp_hits++;
            expect_state(ST_DUCK_DONE, 1'b0, 1'b0);
            clk1(1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            clk1(1'b0, 1'b0, 1'b0, 1'b1);
            clk1(1'b0, 1'b0, 1'b0, 1'b1);
            expect_state(ST_ESCAPE, 1'b1, 1'b0);
            clk1(1'b0, 1'b0, 1'b0, 1'b1);
            bus.duck_show = 1'b0;
            expect_state(ST_DUCK_DONE, 1'b0, 1'b0);
            clk1(1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus.duck_show = 1'b0;
        exp_didx++;
        if (exp_didx == 10) begin
            expect_state(ST_ROUND_RESULT, 1'b0, 1'b0);
        end else begin
            expect_pulse(P_RELOAD);
            expect_state(ST_SPAWN_WAIT, 1'b0, 1'b0);
        end
        clk1(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        snap_t  s;
        pulse_t p;
        int     act;
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            n_cmp++;
            if (s.cyc != cyc || bus.state_code !== s.st || bus.duck_escape !== s.esc ||
                bus.game_over !== s.go || bus.round_num !== s.rnd ||
                bus.duck_idx !== s.didx || bus.hits_in_round !== s.hits) begin
                n_bad++;
                $display("FAIL status@%0d: got st=%0d esc=%0b go=%0b rnd=%0d didx=%0d hits=%0d, want (cyc %0d) st=%0d esc=%0b go=%0b rnd=%0d didx=%0d hits=%0d",
                         cyc, bus.state_code, bus.duck_escape, bus.game_over, bus.round_num,
                         bus.duck_idx, bus.hits_in_round, s.cyc, s.st, s.esc, s.go, s.rnd,
                         s.didx, s.hits);
            end
        end
        if (bus.duck_launch === 1'b1 || bus.ammo_reload === 1'b1) begin
            act = (bus.duck_launch === 1'b1 && bus.ammo_reload === 1'b1) ? 2 :
                  (bus.duck_launch === 1'b1) ? P_LAUNCH : P_RELOAD;
            n_cmp++;
            if (pulse_q.size() == 0) begin
                n_bad++;
                $display("FAIL pulse@%0d: got kind=%0d, want no pulse", cyc, act);
            end else begin
                p = pulse_q.pop_front();
                if (p.kind != act || p.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL pulse@%0d: got kind=%0d, want kind=%0d at cyc %0d",
                             cyc, act, p.kind, p.cyc);
                end
            end
        end
    end

    initial begin
        bus.new_frame  = 1'b0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.hit        = 1'b0;
        bus.shot_fired = 1'b0;
        bus.duck_show  = 1'b0;
        rst       = 1'b0;
        exp_round = 1;
        exp_didx  = 0;
        exp_hits  = 0;
        @(negedge clk);

        // Reset dominates all inputs, then stray events in IDLE do nothing.
        expect_state(ST_IDLE, 1'b0, 1'b0);
        clk1(1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        expect_state(ST_IDLE, 1'b0, 1'b0);
        clk1(1'b1, 1'b0, 1'b1, 1'b1);

        expect_pulse(P_RELOAD);
        expect_state(ST_SPAWN_WAIT, 1'b0, 1'b0);
        clk1(1'b0, 1'b1, 1'b0, 1'b0);
        expect_state(ST_SPAWN_WAIT, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b1, 1'b1);

        // Launch lands exactly on the 61st frame.
        frames(59);
        expect_state(ST_SPAWN_WAIT, 1'b0, 1'b0);
        frames(1);
        expect_pulse(P_LAUNCH);
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        frames(1);
        bus.duck_show = 1'b1;

        // Duck 1: three misses force the escape.
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        expect_state(ST_ESCAPE, 1'b1, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        expect_state(ST_ESCAPE, 1'b1, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        bus.duck_show = 1'b0;
        expect_state(ST_DUCK_DONE, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b0);
        exp_didx = 1;
        expect_pulse(P_RELOAD);
        expect_state(ST_SPAWN_WAIT, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b0);

        // Duck 2: two misses, then hit and shot together -- the hit wins.
        frames(60);
        expect_pulse(P_LAUNCH);
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        frames(1);
        bus.duck_show = 1'b1;
        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        exp_hits = 1;
        expect_state(ST_DUCK_DONE, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b1, 1'b1);
        bus.duck_show = 1'b0;
        exp_didx = 2;
        expect_pulse(P_RELOAD);
        expect_state(ST_SPAWN_WAIT, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b0);

        // Ducks 3..10: five hits (total 6) then three misses.
        for (int i = 3; i <= 10; i++) run_duck(i <= 7);

        // Result hold of 90 frames, then advance to round 2.
        frames(89);
        expect_state(ST_ROUND_RESULT, 1'b0, 1'b0);
        frames(1);
        exp_round = 2;
        exp_didx  = 0;
        exp_hits  = 0;
        expect_pulse(P_RELOAD);
        expect_state(ST_SPAWN_WAIT, 1'b0, 1'b0);
        frames(1);

        run_duck(1'b1);

        // Pause for 200 frames in flight: no timeout, hit and shot ignored.
        frames(60);
        expect_pulse(P_LAUNCH);
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        frames(1);
        bus.duck_show = 1'b1;
        bus.pause     = 1'b1;
        frames(100);
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        clk1(1'b1, 1'b0, 1'b1, 1'b0);
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        clk1(1'b1, 1'b0, 1'b0, 1'b1);
        frames(98);
        bus.pause = 1'b0;
        frames(599);
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        frames(1);
        expect_state(ST_ESCAPE, 1'b1, 1'b0);
        frames(1);

        // Paused escape holds even with the duck gone; start still aborts.
        bus.pause     = 1'b1;
        bus.duck_show = 1'b0;
        expect_state(ST_ESCAPE, 1'b1, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b0);
        exp_round = 1;
        exp_didx  = 0;
        exp_hits  = 0;
        expect_pulse(P_RELOAD);
        expect_state(ST_SPAWN_WAIT, 1'b0, 1'b0);
        clk1(1'b0, 1'b1, 1'b0, 1'b0);
        bus.pause = 1'b0;

        // Only five hits: the round ends in game over.
        for (int i = 1; i <= 10; i++) run_duck(i <= 5);
        frames(90);
        expect_state(ST_GAME_OVER, 1'b0, 1'b1);
        frames(1);
        frames(5);
        expect_state(ST_GAME_OVER, 1'b0, 1'b1);
        clk1(1'b1, 1'b0, 1'b1, 1'b1);
        exp_didx = 0;
        exp_hits = 0;
        expect_pulse(P_RELOAD);
        expect_state(ST_SPAWN_WAIT, 1'b0, 1'b0);
        clk1(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a flight.
        run_duck(1'b1);
        frames(60);
        expect_pulse(P_LAUNCH);
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        frames(1);
        bus.duck_show = 1'b1;
        expect_state(ST_FLIGHT, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b1);
        rst      = 1'b0;
        exp_didx = 0;
        exp_hits = 0;
        expect_state(ST_IDLE, 1'b0, 1'b0);
        clk1(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        expect_state(ST_IDLE, 1'b0, 1'b0);
        clk1(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        @(posedge clk);
        while (snap_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL status_left: got never checked, want check at cyc %0d", snap_q[0].cyc);
            void'(snap_q.pop_front());
        end
        while (pulse_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_missing: got none, want kind=%0d at cyc %0d",
                     pulse_q[0].kind, pulse_q[0].cyc);
            void'(pulse_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
